// File: rtl/pipe_stall_ctl_if.sv
// Purpose: ID-stage sequencer bus. It groups the hazard, MUL/DIV and branch inputs
//          with the pipeline-control and status outputs of pipe_stall_ctl.
// Ports (modport slave = controller side):
//   in : rs, rt, use_rs, use_rt, ern, ewreg, em2reg, is_md, md_ready, md_done, br_taken
//   out: wpcir, dbubble, fflush, md_start, md_tmo, stall_cnt[CNT_W], state[2]
interface pipe_stall_ctl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic             use_rs;
    logic             use_rt;
    logic [4:0]       ern;
    logic             ewreg;
    logic             em2reg;
    logic             is_md;
    logic             md_ready;
    logic             md_done;
    logic             br_taken;

    logic             wpcir;
    logic             dbubble;
    logic             fflush;
    logic             md_start;
    logic             md_tmo;
    logic [CNT_W-1:0] stall_cnt;
    logic [1:0]       state;

    // Pipeline side: drives ID/EX status, observes control outputs
    modport master (
        output rs, rt, use_rs, use_rt, ern, ewreg, em2reg,
               is_md, md_ready, md_done, br_taken,
        input  wpcir, dbubble, fflush, md_start, md_tmo, stall_cnt, state
    );

    // Controller side
    modport slave (
        input  rs, rt, use_rs, use_rt, ern, ewreg, em2reg,
               is_md, md_ready, md_done, br_taken,
        output wpcir, dbubble, fflush, md_start, md_tmo, stall_cnt, state
    );
endinterface

// File: rtl/pipe_stall_ctl.sv
// Purpose: ID-stage pipeline sequencer. It stalls one cycle on a load-use hazard
//          against the EX load, issues MUL/DIV and holds ID until the result is back,
//          flushes IF on taken branches when there is no delay slot, counts stall cycles
//          and raises a sticky watchdog error if the multi-cycle unit never answers.
// Ports:
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : pipe_stall_ctl_if.slave (hazard/MD/branch inputs, wpcir/dbubble/fflush/
//            md_start control outputs, md_tmo, stall_cnt and state status)
module pipe_stall_ctl #(
    parameter bit          DELAY_SLOT = 1'b1,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MD_TMO     = 64
) (
    input  logic             clock,
    input  logic             resetn,
    pipe_stall_ctl_if.slave  bus
);

    localparam int unsigned WD_W = $clog2(MD_TMO) + 1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        MD_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [WD_W-1:0]  wd_q;
    logic             md_tmo_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic lu_haz_c;
    logic wpcir_c;
    logic dbubble_c;
    logic fflush_c;
    logic md_start_c;

    // Load in EX whose destination is a register the ID instruction actually reads
    assign lu_haz_c = bus.ewreg && bus.em2reg && (bus.ern != 5'd0) &&
                      ((bus.use_rs && (bus.ern == bus.rs)) ||
                       (bus.use_rt && (bus.ern == bus.rt)));

    // Pipeline control decode from the current state and ID/EX status
    always_comb begin
        wpcir_c    = 1'b1;
        dbubble_c  = 1'b0;
        fflush_c   = 1'b0;
        md_start_c = 1'b0;
        case (state_q)
            RUN: begin
                if (lu_haz_c) begin
                    wpcir_c   = 1'b0;
                    dbubble_c = 1'b1;
                end else if (bus.is_md) begin
                    // Hold ID either way; only start the unit when it can accept
                    wpcir_c    = 1'b0;
                    dbubble_c  = 1'b1;
                    md_start_c = bus.md_ready;
                end else if (bus.br_taken) begin
                    fflush_c = ~DELAY_SLOT;
                end
            end
            MD_WAIT: begin
                wpcir_c   = 1'b0;
                dbubble_c = 1'b1;
            end
            default: ;
        endcase
    end

    // Sequencer state, watchdog, sticky timeout and saturating stall counter
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= RUN;
            wd_q        <= '0;
            md_tmo_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (!wpcir_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            case (state_q)
                RUN: begin
                    if (md_start_c) begin
                        state_q <= MD_WAIT;
                        wd_q    <= '0;
                    end
                end
                MD_WAIT: begin
                    wd_q <= wd_q + WD_W'(1);
                    // A result arriving on the last allowed cycle still counts as on time
                    if (bus.md_done) begin
                        state_q <= MD_DONE;
                    end else if (wd_q == WD_W'(MD_TMO - 1)) begin
                        md_tmo_q <= 1'b1;
                        state_q  <= MD_DONE;
                    end
                end
                MD_DONE: state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.wpcir     = wpcir_c;
    assign bus.dbubble   = dbubble_c;
    assign bus.fflush    = fflush_c;
    assign bus.md_start  = md_start_c;
    assign bus.md_tmo    = md_tmo_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_pipe_stall_ctl.sv
// Purpose: self-checking bench for pipe_stall_ctl. Two instances share the same
//          stimulus: d0 (no delay slot, 16-bit counter) and d1 (delay slot, 4-bit
//          counter), both with an 8-cycle MUL/DIV watchdog. A cycle-level reference
//          model predicts every output each cycle.
module tb_pipe_stall_ctl;

    localparam int TMO = 8;

    logic       clock;
    logic       resetn;
    logic [4:0] rs, rt, ern;
    logic       use_rs, use_rt, ewreg, em2reg, is_md, md_ready, md_done, br_taken;

    int n_chk  = 0;
    int n_pass = 0;

    pipe_stall_ctl_if #(.CNT_W(16)) if0 ();
    pipe_stall_ctl_if #(.CNT_W(4))  if1 ();

    assign if0.rs = rs;         assign if1.rs = rs;
    assign if0.rt = rt;         assign if1.rt = rt;
    assign if0.use_rs = use_rs; assign if1.use_rs = use_rs;
    assign if0.use_rt = use_rt; assign if1.use_rt = use_rt;
    assign if0.ern = ern;       assign if1.ern = ern;
    assign if0.ewreg = ewreg;   assign if1.ewreg = ewreg;
    assign if0.em2reg = em2reg; assign if1.em2reg = em2reg;
    assign if0.is_md = is_md;   assign if1.is_md = is_md;
    assign if0.md_ready = md_ready; assign if1.md_ready = md_ready;
    assign if0.md_done = md_done;   assign if1.md_done = md_done;
    assign if0.br_taken = br_taken; assign if1.br_taken = br_taken;

    pipe_stall_ctl #(.DELAY_SLOT(1'b0), .CNT_W(16), .MD_TMO(TMO)) dut0 (
        .clock (clock),
        .resetn(resetn),
        .bus   (if0.slave)
    );

    pipe_stall_ctl #(.DELAY_SLOT(1'b1), .CNT_W(4), .MD_TMO(TMO)) dut1 (
        .clock (clock),
        .resetn(resetn),
        .bus   (if1.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: phase 0=running, 1=waiting on MUL/DIV, 2=result cycle
    int ph[2];
    int wd[2];
    int cnt[2];
    int tmo[2];
    int cmax[2] = '{65535, 15};
    int ds[2]   = '{0, 1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic clear_in();
        rs = '0; rt = '0; ern = '0;
        use_rs = 0; use_rt = 0; ewreg = 0; em2reg = 0;
        is_md = 0; md_ready = 0; md_done = 0; br_taken = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ph[i] = 0; wd[i] = 0; cnt[i] = 0; tmo[i] = 0;
        end
    endtask

    // Compare one instance's outputs with the model's predictions
    task automatic check_dut(input int i, input int ew, input int eb, input int ef, input int es);
        logic [31:0] gw, gb, gf, gs, gst, gc, gt;
        if (i == 0) begin
            gw = 32'(if0.wpcir); gb = 32'(if0.dbubble); gf = 32'(if0.fflush);
            gs = 32'(if0.md_start); gst = 32'(if0.state);
            gc = 32'(if0.stall_cnt); gt = 32'(if0.md_tmo);
        end else begin
            gw = 32'(if1.wpcir); gb = 32'(if1.dbubble); gf = 32'(if1.fflush);
            gs = 32'(if1.md_start); gst = 32'(if1.state);
            gc = 32'(if1.stall_cnt); gt = 32'(if1.md_tmo);
        end
        chk($sformatf("d%0d wpcir", i),     gw,  32'(ew));
        chk($sformatf("d%0d dbubble", i),   gb,  32'(eb));
        chk($sformatf("d%0d fflush", i),    gf,  32'(ef));
        chk($sformatf("d%0d md_start", i),  gs,  32'(es));
        chk($sformatf("d%0d state", i),     gst, 32'(ph[i]));
        chk($sformatf("d%0d stall_cnt", i), gc,  32'(cnt[i]));
        chk($sformatf("d%0d md_tmo", i),    gt,  32'(tmo[i]));
    endtask

    // One clock: check at the falling edge, advance the model, then move past the rising edge
    task automatic step();
        bit lu;
        int ew, eb, ef, es, nph;
        @(negedge clock);
        lu = ewreg && em2reg && (ern != 0) &&
             ((use_rs && (ern == rs)) || (use_rt && (ern == rt)));
        for (int i = 0; i < 2; i++) begin
            ew = 1; eb = 0; ef = 0; es = 0; nph = ph[i];
            if (ph[i] == 0) begin
                if (lu) begin
                    ew = 0; eb = 1;
                end else if (is_md) begin
                    ew = 0; eb = 1;
                    if (md_ready) begin es = 1; nph = 1; end
                end else if (br_taken) begin
                    ef = (ds[i] == 0) ? 1 : 0;
                end
            end else if (ph[i] == 1) begin
                ew = 0; eb = 1;
            end else begin
                nph = 0;
            end
            check_dut(i, ew, eb, ef, es);
            if (ew == 0 && cnt[i] < cmax[i]) cnt[i]++;
            if (ph[i] == 0 && es == 1) wd[i] = 0;
            if (ph[i] == 1) begin
                if (md_done) nph = 2;
                else if (wd[i] == TMO - 1) begin tmo[i] = 1; nph = 2; end
                wd[i]++;
            end
            ph[i] = nph;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clear_in();
        resetn = 1'b0;
        #1;
        chk("rst d0 state", 32'(if0.state), 32'd0);
        chk("rst d0 cnt",   32'(if0.stall_cnt), 32'd0);
        chk("rst d0 tmo",   32'(if0.md_tmo), 32'd0);
        chk("rst d1 state", 32'(if1.state), 32'd0);
        chk("rst d1 cnt",   32'(if1.stall_cnt), 32'd0);
        chk("rst d1 wpcir", 32'(if1.wpcir), 32'd1);
        model_reset();
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        do_reset();

        // Load-use hazard on rs: one stall cycle, then the load has moved on
        ewreg = 1; em2reg = 1; ern = 5'd5; rs = 5'd5; use_rs = 1;
        step();
        em2reg = 0;
        step();
        chk("lu cnt", 32'(if0.stall_cnt), 32'd1);

        // r0 destination and unused rt never stall
        clear_in(); ewreg = 1; em2reg = 1; ern = 5'd0; rs = 5'd0; use_rs = 1;
        step();
        clear_in(); ewreg = 1; em2reg = 1; ern = 5'd7; rt = 5'd7; rs = 5'd3; use_rs = 1; use_rt = 0;
        step();
        use_rt = 1;
        step();

        // MUL issue with result 4 cycles after start
        do_reset();
        is_md = 1; md_ready = 1;
        step();
        md_ready = 0;
        repeat (3) step();
        md_done = 1;
        step();
        md_done = 0;
        step();
        is_md = 0;
        step();
        chk("md cnt",   32'(if0.stall_cnt), 32'd5);
        chk("md state", 32'(if0.state), 32'd0);

        // MUL waiting for a busy unit, then branches with and without a hazard
        is_md = 1; md_ready = 0;
        repeat (2) step();
        clear_in(); br_taken = 1;
        step();
        ewreg = 1; em2reg = 1; ern = 5'd9; rt = 5'd9; use_rt = 1;
        step();

        // Watchdog: result never arrives
        do_reset();
        is_md = 1; md_ready = 1;
        step();
        md_ready = 0;
        repeat (8) step();
        chk("wd tmo",   32'(if0.md_tmo), 32'd1);
        chk("wd state", 32'(if0.state), 32'd2);
        is_md = 0;
        repeat (3) step();
        chk("wd sticky", 32'(if1.md_tmo), 32'd1);
        chk("wd cnt",    32'(if0.stall_cnt), 32'd9);

        // Reset while waiting on MUL/DIV
        do_reset();
        is_md = 1; md_ready = 1;
        step();
        md_ready = 0; is_md = 0;
        repeat (2) step();
        chk("mid state", 32'(if0.state), 32'd1);
        do_reset();
        repeat (2) step();

        // Counter saturation on the narrow instance
        ewreg = 1; em2reg = 1; ern = 5'd4; rs = 5'd4; use_rs = 1;
        repeat (20) step();
        chk("sat d1 cnt", 32'(if1.stall_cnt), 32'd15);
        chk("sat d0 cnt", 32'(if0.stall_cnt), 32'd20);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rs       = 5'($urandom_range(0, 3));
            rt       = 5'($urandom_range(0, 3));
            ern      = 5'($urandom_range(0, 3));
            use_rs   = 1'($urandom_range(0, 1));
            use_rt   = 1'($urandom_range(0, 1));
            ewreg    = 1'($urandom_range(0, 1));
            em2reg   = ($urandom_range(0, 2) == 0);
            is_md    = ($urandom_range(0, 3) == 0);
            md_ready = 1'($urandom_range(0, 1));
            md_done  = ($urandom_range(0, 5) == 0);
            br_taken = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
